exp2_fp8: RTL

EXP2_FP8 -- requirements
Module: exp2_fp8

---
 rtl/exp2_fp8.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/exp2_fp8.sv
// exp2_fp8: y = 2^x for E4M3 operands, 3-stage pipeline (decode, LUT/exponent, pack).
// Optional macro EXP2_SUBNORM_EN produces subnormal results instead of flushing them to zero.
module exp2_fp8 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic [1:0] out_flags
);

   // Handshake: a transfer happens on a port when valid & ready are both high at a
   // rising edge; a stage holds its contents while it is valid and cannot move on.
   logic       rdy_q;
   logic       s1_v_q, s2_v_q, s3_v_q;
   logic       s1_en, s2_en, s3_en, accept;

   logic [9:0] s1_fix_q, s1_fix_d;
   logic       s1_nan_q, s1_nan_d;
   logic [5:0] s2_e_q, s2_e_d;
   logic [2:0] s2_mant_q, s2_mant_d;
   logic       s2_nan_q;
   logic [7:0] s3_data_q, s3_data_d;
   logic [1:0] s3_flags_q, s3_flags_d;

   // A stage may load when it is empty or the stage after it is moving.
   assign s3_en    = !s3_v_q || out_ready;
   assign s2_en    = !s2_v_q || s3_en;
   assign s1_en    = !s1_v_q || s2_en;
   assign in_ready = rdy_q && s1_en;
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_q  <= 1'b0;
         s1_v_q <= 1'b0;
         s2_v_q <= 1'b0;
         s3_v_q <= 1'b0;
      end else begin
         rdy_q <= 1'b1;
         if (s1_en) s1_v_q <= accept;
         if (s2_en) s2_v_q <= s1_v_q;
         if (s3_en) s3_v_q <= s2_v_q;
      end
   end

   always_ff @(posedge clk) begin
      if (s1_en) begin
         s1_fix_q <= s1_fix_d;
         s1_nan_q <= s1_nan_d;
      end
      if (s2_en) begin
         s2_e_q    <= s2_e_d;
         s2_mant_q <= s2_mant_d;
         s2_nan_q  <= s1_nan_q;
      end
      if (s3_en) begin
         s3_data_q  <= s3_data_d;
         s3_flags_q <= s3_flags_d;
      end
   end

   // S1: x*16 as floor, via v = |x| * 2^10 so the fraction sits in v[5:0].
   logic [18:0] s1_v;
   logic [12:0] s1_ip;
   logic        s1_fr;

   always_comb begin
      s1_nan_d = (in_data[6:3] == 4'hF) && (in_data[2:0] == 3'h7);
      if (in_data[6:3] == 4'h0) s1_v = {15'd0, in_data[2:0], 1'b0};
      else                      s1_v = 19'({1'b1, in_data[2:0]}) << in_data[6:3];
      s1_ip = s1_v[18:6];
      s1_fr = |s1_v[5:0];
      if (!in_data[7]) begin
         s1_fix_d = (s1_ip > 13'd144) ? 10'd144 : s1_ip[9:0];
      end else if ((s1_ip > 13'd160) || ((s1_ip == 13'd160) && s1_fr)) begin
         s1_fix_d = 10'h360;
      end else begin
         s1_fix_d = 10'd0 - s1_ip[9:0] - {9'd0, s1_fr};
      end
   end

   // S2: integer part becomes the biased exponent, fraction indexes the mantissa LUT.
   logic [9:0] s2_n;

   always_comb begin
      s2_n   = 10'($signed(s1_fix_q) >>> 4);
      s2_e_d = s2_n[5:0] + 6'd7;
      case (s1_fix_q[3:0])
         4'd0, 4'd1:        s2_mant_d = 3'd0;
         4'd2, 4'd3:        s2_mant_d = 3'd1;
         4'd4, 4'd5, 4'd6:  s2_mant_d = 3'd2;
         4'd7, 4'd8:        s2_mant_d = 3'd3;
         4'd9, 4'd10:       s2_mant_d = 3'd4;
         4'd11, 4'd12:      s2_mant_d = 3'd5;
         4'd13:             s2_mant_d = 3'd6;
         default:           s2_mant_d = 3'd7;
      endcase
   end

   // S3: pack; flags are {sat, uf}.
   logic signed [5:0] s3_e;
`ifdef EXP2_SUBNORM_EN
   logic [5:0] s3_sh;
   logic [3:0] s3_wide;
`endif

   always_comb begin
      s3_e       = $signed(s2_e_q);
      s3_data_d  = 8'h00;
      s3_flags_d = 2'b01;
`ifdef EXP2_SUBNORM_EN
      s3_sh   = 6'd1 - s2_e_q;
      s3_wide = {1'b1, s2_mant_q} >> s3_sh;
`endif
      if (s2_nan_q) begin
         s3_data_d  = 8'h7F;
         s3_flags_d = 2'b00;
      end else if ((s3_e >= 6'sd16) || ((s3_e == 6'sd15) && (s2_mant_q == 3'd7))) begin
         s3_data_d  = 8'h7E;
         s3_flags_d = 2'b10;
      end else if (s3_e >= 6'sd1) begin
         s3_data_d  = {1'b0, s2_e_q[3:0], s2_mant_q};
         s3_flags_d = 2'b00;
      end else if (s3_e >= -6'sd2) begin
`ifdef EXP2_SUBNORM_EN
         s3_data_d  = {5'd0, s3_wide[2:0]};
         s3_flags_d = {1'b0, s3_wide[2:0] == 3'd0};
`else
         s3_data_d  = 8'h00;
         s3_flags_d = 2'b01;
`endif
      end
   end

   // Result fields read as zero whenever no result is held, including during reset.
   assign out_valid = s3_v_q;
   assign out_data  = s3_v_q ? s3_data_q : 8'h00;
   assign out_flags = s3_v_q ? s3_flags_q : 2'b00;

endmodule
